// File: rtl/tinynpu_pkg.sv
// Shared TinyNPU types and default datapath widths.
// Used by the MAC-side output stage and its requantizer lanes.
package tinynpu_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

    localparam int NPU_SIZE   = 4;
    localparam int NPU_ACC_W  = 32;
    localparam int NPU_DATA_W = 16;
    localparam int NPU_FRAC_W = 8;

    // Index width that stays legal for a single-column array.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tinynpu_requant.sv
// One requantizer lane: floor shift, signed saturation, optional ReLU.
// Purely combinational, zero latency, no flow control.
module tinynpu_requant
    import tinynpu_pkg::*;
#(
    parameter int ACC_W  = NPU_ACC_W,
    parameter int DATA_W = NPU_DATA_W,
    parameter int FRAC_W = NPU_FRAC_W
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic              relu_en_i,
    output logic [DATA_W-1:0] res_o
);

    // Output range expressed at accumulator width so the compare is exact.
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    logic signed [ACC_W-1:0] shifted;
    logic [DATA_W-1:0]       sat;

    always_comb begin
        shifted = $signed(acc_i) >>> FRAC_W;
        if (shifted > MAX_V) begin
            sat = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < MIN_V) begin
            sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat = shifted[DATA_W-1:0];
        end
        res_o = (relu_en_i && sat[DATA_W-1]) ? '0 : sat;
    end

endmodule

// File: rtl/tinynpu_ostream_drain.sv
// Captures SIZE requantized accumulators on a strobe and streams them out one per val/rdy transfer.
// First element valid one cycle after capture; holds under backpressure; strobes during a drain are dropped and flagged.
module tinynpu_ostream_drain
    import tinynpu_pkg::*;
#(
    parameter int SIZE   = NPU_SIZE,
    parameter int ACC_W  = NPU_ACC_W,
    parameter int DATA_W = NPU_DATA_W,
    parameter int FRAC_W = NPU_FRAC_W,
    parameter int IDX_W  = idx_width(SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       c2d_ostream_req,
    input  logic [SIZE-1:0][ACC_W-1:0] mac_ostream_data,
    input  logic                       relu_en,
    output logic [DATA_W-1:0]          ostream_msg,
    output logic [IDX_W-1:0]           ostream_idx,
    output logic                       ostream_last,
    output logic                       ostream_val,
    input  logic                       ostream_rdy,
    output logic                       d2c_ostream_busy,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    drain_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] elem_q [SIZE];
    logic [DATA_W-1:0] lane_res [SIZE];

    logic xfer;
    logic at_last;
    logic last_xfer;
    logic capture;
    logic drop;

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
        tinynpu_requant #(
            .ACC_W (ACC_W),
            .DATA_W(DATA_W),
            .FRAC_W(FRAC_W)
        ) u_requant (
            .acc_i    (mac_ostream_data[gi]),
            .relu_en_i(relu_en),
            .res_o    (lane_res[gi])
        );
    end

    always_comb begin
        xfer      = ostream_val && ostream_rdy;
        at_last   = (idx_q == LAST_IDX);
        last_xfer = xfer && at_last;
        // The final transfer frees the buffer, so a strobe in that cycle is accepted.
        capture   = c2d_ostream_req && ((state_q == ST_IDLE) || last_xfer);
        drop      = c2d_ostream_req && (state_q == ST_DRAIN) && !last_xfer;

        state_d = state_q;
        idx_d   = idx_q;
        if (capture) begin
            state_d = ST_DRAIN;
            idx_d   = '0;
        end else if (xfer) begin
            if (at_last) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Buffer contents are irrelevant while idle, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < SIZE; i++) begin
                elem_q[i] <= lane_res[i];
            end
        end
    end

    assign ostream_val      = (state_q == ST_DRAIN);
    assign d2c_ostream_busy = (state_q == ST_DRAIN);
    assign ostream_idx      = idx_q;
    assign ostream_msg      = elem_q[idx_q];
    assign ostream_last     = ostream_val && at_last;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_tinynpu_ostream_drain.sv
// Directed plus randomized bench for tinynpu_ostream_drain against a queue-based reference model.
module tb_tinynpu_ostream_drain;

    localparam int SIZE   = 4;
    localparam int ACC_W  = 32;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       c2d_ostream_req;
    logic [SIZE-1:0][ACC_W-1:0] mac_ostream_data;
    logic                       relu_en;
    logic [DATA_W-1:0]          ostream_msg;
    logic [1:0]                 ostream_idx;
    logic                       ostream_last;
    logic                       ostream_val;
    logic                       ostream_rdy;
    logic                       d2c_ostream_busy;
    logic                       overrun;
    logic                       overrun_clr;

    always #5 clk = ~clk;

    tinynpu_ostream_drain #(
        .SIZE  (SIZE),
        .ACC_W (ACC_W),
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .c2d_ostream_req (c2d_ostream_req),
        .mac_ostream_data(mac_ostream_data),
        .relu_en         (relu_en),
        .ostream_msg     (ostream_msg),
        .ostream_idx     (ostream_idx),
        .ostream_last    (ostream_last),
        .ostream_val     (ostream_val),
        .ostream_rdy     (ostream_rdy),
        .d2c_ostream_busy(d2c_ostream_busy),
        .overrun         (overrun),
        .overrun_clr     (overrun_clr)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: elements still owed to the consumer, plus the sticky flag.
    logic [DATA_W-1:0] exp_q [$];
    bit                m_ovr;
    bit                after_rst;

    function automatic logic [DATA_W-1:0] ref_rq(input logic [ACC_W-1:0] a, input bit relu);
        longint v, d, r, s, hi, lo;
        v  = longint'($signed(a));
        d  = longint'(1) << FRAC_W;
        r  = v % d;
        if (r < 0) r += d;
        s  = (v - r) / d;
        hi = (longint'(1) << (DATA_W - 1)) - 1;
        lo = -hi - 1;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        if (relu && s < 0) s = 0;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] rand_acc();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return {{8{r[23]}}, r[23:0]};
            2:       return {{20{r[11]}}, r[11:0]};
            default: return r[0] ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Check outputs at the falling edge, then drive inputs and advance the model for the next rising edge.
    task automatic cycle(input bit req, input logic [SIZE-1:0][ACC_W-1:0] acc, input bit relu,
                         input bit rdy, input bit clr, input bit rs);
        int n;
        bit xfer, accept;
        @(negedge clk);
        n = exp_q.size();
        chk("val", {31'b0, ostream_val}, {31'b0, n != 0});
        chk("busy", {31'b0, d2c_ostream_busy}, {31'b0, n != 0});
        chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
        if (n != 0) begin
            chk("msg", {16'b0, ostream_msg}, {16'b0, exp_q[0]});
            chk("idx", {30'b0, ostream_idx}, 32'(SIZE - n));
            chk("last", {31'b0, ostream_last}, {31'b0, n == 1});
        end else begin
            chk("last_idle", {31'b0, ostream_last}, 32'd0);
        end
        if (after_rst) chk("idx_after_rst", {30'b0, ostream_idx}, 32'd0);

        c2d_ostream_req  = req;
        mac_ostream_data = acc;
        relu_en          = relu;
        ostream_rdy      = rdy;
        overrun_clr      = clr;
        rst              = rs;

        xfer   = (n != 0) && rdy;
        accept = req && (n == 0 || (n == 1 && xfer));
        if (rs) begin
            exp_q.delete();
            m_ovr     = 1'b0;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (xfer) void'(exp_q.pop_front());
            if (accept) for (int i = 0; i < SIZE; i++) exp_q.push_back(ref_rq(acc[i], relu));
            if (req && !accept) m_ovr = 1'b1;
            else if (clr)       m_ovr = 1'b0;
        end
    endtask

    task automatic run(input int k, input bit rdy);
        for (int i = 0; i < k; i++) cycle(1'b0, '0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    logic [SIZE-1:0][ACC_W-1:0] v1, v2, v3, vr;
    bit                         pat [7];

    initial begin
        rst = 1'b1; c2d_ostream_req = 1'b0; mac_ostream_data = '0;
        relu_en = 1'b0; ostream_rdy = 1'b0; overrun_clr = 1'b0;
        exp_q.delete(); m_ovr = 1'b0; after_rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic drain
        v1 = {32'h0000_0000, 32'hFFFF_FD00, 32'h0000_0280, 32'h0000_0100};
        cycle(1'b1, v1, 1'b0, 1'b1, 1'b0, 1'b0);
        run(6, 1'b1);

        // Saturation and floor rounding
        v2 = {32'h007F_FF00, 32'hFFFF_FE80, 32'h8000_0000, 32'h7FFF_FFFF};
        cycle(1'b1, v2, 1'b0, 1'b1, 1'b0, 1'b0);
        run(6, 1'b1);

        // ReLU sampled at capture; toggling afterwards must not matter
        v3 = {32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0300, 32'hFFFF_FD00};
        cycle(1'b1, v3, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, v3, i[0], 1'b1, 1'b0, 1'b0);

        // Backpressure pattern
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        cycle(1'b1, v1, 1'b0, 1'b0, 1'b0, 1'b0);
        foreach (pat[i]) cycle(1'b0, '0, 1'b0, pat[i], 1'b0, 1'b0);
        run(3, 1'b1);

        // Back-to-back: strobe in the last-transfer cycle
        cycle(1'b1, v1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(3, 1'b1);
        cycle(1'b1, v2, 1'b0, 1'b1, 1'b0, 1'b0);
        run(6, 1'b1);

        // Strobe at idx 1 is dropped; overrun sticks, set beats clear
        cycle(1'b1, v1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, v3, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, v3, 1'b1, 1'b1, 1'b1, 1'b0);
        run(5, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        run(2, 1'b0);

        // Reset mid-drain at idx 2, with a strobe in the same cycle
        cycle(1'b1, v2, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, v1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, v1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, v3, 1'b0, 1'b1, 1'b0, 1'b0);
        run(6, 1'b1);

        // Randomized traffic
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < SIZE; i++) vr[i] = rand_acc();
            cycle($urandom_range(0, 3) == 0, vr, 1'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        end
        run(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tinynpu_ostream_drain.md
Name: tinynpu_ostream_drain

Overview:
Output stage directly downstream of the TinyNPU MAC array and controller. On the controller's one-cycle c2d_ostream_req pulse, it captures the SIZE per-column accumulators and requantizes each one: arithmetic right shift, signed saturation, optional ReLU. It then serializes the results one element per transfer over a val/rdy stream to the host or writeback path. It also reports busy and a sticky overrun so the controller and software can throttle back-to-back MAC passes.

Parameters:
SIZE, 4, number of MAC columns, i.e. elements per output vector
ACC_W, 32, signed accumulator width from the MAC array
DATA_W, 16, signed output element width
FRAC_W, 8, arithmetic right-shift amount applied to each accumulator (0 <= FRAC_W < ACC_W)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
c2d_ostream_req  input  1  one-cycle capture strobe from controller
mac_ostream_data  input  ACC_W x [SIZE]  signed accumulators, valid in the cycle c2d_ostream_req is high
relu_en  input  1  when 1, negative results are forced to 0; sampled at capture
ostream_msg  output  DATA_W  current requantized element
ostream_idx  output  $clog2(SIZE)  index of current element
ostream_last  output  1  high when ostream_val and ostream_idx == SIZE-1
ostream_val  output  1  element valid
ostream_rdy  input  1  consumer ready; transfer = val & rdy
d2c_ostream_busy  output  1  high whenever state is DRAIN
overrun  output  1  sticky; a capture strobe was dropped
overrun_clr  input  1  clears overrun

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, ostream_val=0, ostream_idx=0, ostream_last=0, busy=0, overrun=0, buffer contents don't-care. Reset mid-drain abandons the vector with no further transfers.
- States:
  - IDLE: ostream_val=0. On c2d_ostream_req, latch SIZE processed elements into the buffer, set idx=0, and move to DRAIN next cycle. First ostream_val is one cycle after the strobe.
  - DRAIN: ostream_val=1 and ostream_msg=buf[idx].
    - A transfer with idx<SIZE-1 increments idx.
    - A transfer with idx==SIZE-1 returns to IDLE. If c2d_ostream_req is high in that same cycle, it instead recaptures, sets idx=0 and stays in DRAIN, giving back-to-back vectors with no bubble.
- Requantization per lane, computed at capture, registered into the buffer:
  - s = acc >>> FRAC_W (arithmetic shift, floor rounding, no round-to-nearest).
  - If s > 2^(DATA_W-1)-1, output 0x7FFF (for DATA_W=16). If s < -2^(DATA_W-1), output 0x8000. Otherwise output the low DATA_W bits of s.
  - If relu_en and the result is negative, output 0.
- Handshake:
  - ostream_msg, ostream_idx and ostream_last hold stable while val=1 and rdy=0.
  - val never drops before a transfer; no combinational path from rdy to val.
  - rdy is ignored in IDLE.
- Capture while DRAIN, other than the last-transfer cycle above: the strobe is dropped, the buffer is unchanged and overrun is set to 1. Overrun stays set until overrun_clr or rst.
  - If overrun_clr and a new overrun event occur in the same cycle, the set wins.
- Capture and rst in the same cycle: rst wins.
- d2c_ostream_busy equals (state==DRAIN). It is registered, so it asserts the cycle after capture.

Decomposition:
- Shared package tinynpu_pkg:
  - drain state enum (IDLE, DRAIN).
  - Default width constants ACC_W/DATA_W/FRAC_W, shared with the MAC datapath.
- Sub-module tinynpu_requant (purely combinational: shift, saturate, ReLU on one lane), instantiated SIZE times via generate.
- The top-level holds the state machine, buffer, index counter and overrun flag.

Test Plan:
1. Basic drain: SIZE=4, FRAC_W=8, relu_en=0, acc={0x00000100, 0x00000280, 0xFFFFFD00, 0x00000000}, rdy=1 → transfers 0x0001, 0x0002, 0xFFFD, 0x0000 on consecutive cycles starting 1 cycle after the strobe. Last is high only on idx 3; busy for 4 cycles.
2. Saturation and floor: acc={0x7FFFFFFF, 0x80000000, 0xFFFFFE80, 0x007FFF00} → 0x7FFF, 0x8000, 0xFFFE (-2, floor of -1.5), 0x7FFF.
3. ReLU: relu_en=1 at capture, acc={0xFFFFFD00, 0x00000300, 0xFFFFFFFF, 0x00000100} → 0x0000, 0x0003, 0x0000, 0x0001. Toggling relu_en during the drain has no effect.
4. Backpressure: rdy pattern 1,0,0,1,0,1,1 → msg/idx held stable during low cycles, exactly 4 transfers in order, no duplicates or skips.
5. Back-to-back and overrun:
   - A strobe in the last-transfer cycle → the second vector starts the next cycle at idx 0 and overrun stays 0.
   - A strobe at idx 1 → dropped, the original vector completes intact, overrun=1 until overrun_clr pulses.
6. Reset mid-drain: rst at idx 2 → next cycle val=0, idx=0, busy=0, overrun=0. A new strobe afterwards drains normally from idx 0.
